acumulador_somatorio: RTL

- Sequential accumulator that produces the 8-bit `somatorio` bus, which the downstream threshold/LED signalling stage consumes.
- Accepts operand values through a valid/ready handshake and adds each accepted value to a running sum that saturates at 255.
- Counts how many operands were accepted.
- Raises and holds a registered alert when the sum reaches LIMIAR; the alert stays up until acknowledged or cleared.

---
 rtl/acumulador_somatorio.sv | 100 ++++++++++
 1 files changed

// File: rtl/acumulador_somatorio.sv
// Saturating running-sum accumulator with a valid/ready input handshake, an
// accepted-operand counter and a latched threshold alert that is cleared by acknowledge or clear.
module acumulador_somatorio #(
    parameter int LARGURA = 8,
    parameter int LIMIAR  = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] valor,
    input  logic               valor_valido,
    output logic               valor_pronto,
    input  logic               limpar,
    input  logic               reconhecer,
    output logic [LARGURA-1:0] somatorio,
    output logic [LARGURA-1:0] contagem,
    output logic               alerta,
    output logic               estouro
);

    localparam logic [LARGURA-1:0] LIMIAR_V = LIMIAR[LARGURA-1:0];
    localparam logic [LARGURA-1:0] MAXIMO   = {LARGURA{1'b1}};

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMANDO = 2'd1,
        ALERTA  = 2'd2
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] soma_q, soma_d;
    logic [LARGURA-1:0] cont_q, cont_d;
    logic               alerta_q, alerta_d;
    logic               estouro_q, estouro_d;

    logic               aceita;
    logic [LARGURA:0]   soma_ext;
    logic               satura;
    logic [LARGURA-1:0] soma_nova;

    // Ready depends on state only, so the source never sees a combinational loop.
    assign valor_pronto = (estado_q != ALERTA);
    assign aceita       = valor_valido & valor_pronto & ~limpar;

    assign soma_ext  = {1'b0, soma_q} + {1'b0, valor};
    assign satura    = soma_ext[LARGURA];
    assign soma_nova = satura ? MAXIMO : soma_ext[LARGURA-1:0];

    always_comb begin
        estado_d  = estado_q;
        soma_d    = soma_q;
        cont_d    = cont_q;
        alerta_d  = alerta_q;
        estouro_d = estouro_q;

        if (limpar || (estado_q == ALERTA && reconhecer)) begin
            estado_d  = OCIOSO;
            soma_d    = '0;
            cont_d    = '0;
            alerta_d  = 1'b0;
            estouro_d = 1'b0;
        end else if (aceita) begin
            soma_d = soma_nova;
            if (cont_q != MAXIMO) begin
                cont_d = cont_q + 1'b1;
            end
            if (satura) begin
                estouro_d = 1'b1;
            end
            // Alert is decided from the new sum so it rises with the crossing value.
            if (soma_nova >= LIMIAR_V) begin
                estado_d = ALERTA;
                alerta_d = 1'b1;
            end else begin
                estado_d = SOMANDO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            soma_q    <= '0;
            cont_q    <= '0;
            alerta_q  <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            soma_q    <= soma_d;
            cont_q    <= cont_d;
            alerta_q  <= alerta_d;
            estouro_q <= estouro_d;
        end
    end

    assign somatorio = soma_q;
    assign contagem  = cont_q;
    assign alerta    = alerta_q;
    assign estouro   = estouro_q;

endmodule
